mem_stage_sb: RTL and testbench
===============================

Name: mem_stage_sb

Overview:
Parametrised successor to the EX/M pipeline register plus data-memory stage. Holds one M-stage op and applies the late WB→M store-data forward. Stores retire through a SB_DEPTH-entry store buffer into an internal single-port data memory. Loads read that memory with byte/half/word sign or zero extension and register the result toward WB.

Parameters:
ADDR_W, 10, word-address bits of internal DM (2^ADDR_W words, 32-bit)
SB_DEPTH, 4, store-buffer entries (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; 0 clears all state
in_valid  in  1  E stage offers an op
in_ready  out  1  M register can accept (=!stall)
in_instr  in  32  instruction
in_pc  in  32  instruction PC
in_aluout  in  32  effective address / ALU result
in_rtdata  in  32  store data from E
in_rd  in  1  op is load
in_wr  in  1  op is store (in_rd&in_wr never both 1)
in_size  in  2  00 byte, 01 half, 10 word
in_unsigned  in  1  zero-extend load
fwd_sel  in  1  1: use fwd_data as store data
fwd_data  in  32  forwarded WB result
sb_hold  in  1  block draining (maintenance/test)
out_valid  out  1  WB register holds completed op
out_instr  out  32  registered instruction
out_pc  out  32  registered PC
out_pc8  out  32  out_pc+8
out_aluout  out  32  registered ALU result
out_memdata  out  32  extended load data, 0 for non-loads
out_misalign  out  1  op had misaligned address
sb_count  out  log2(SB_DEPTH)+1  valid SB entries
sb_empty  out  1  sb_count==0

Behaviour:
- Reset (reset=0, async): M valid=0, SB empty, DM all zero, out_valid=0, all out_* = 0. Buffered stores are discarded.
- Capture: on posedge, if in_valid&&in_ready, M reg loads in_* and sets M valid. Else if M op completes, M valid=0. Else M reg holds.
- Byte order is little-endian. Byte lane = addr[1:0]. Word index = addr[ADDR_W+1:2]; upper bits are ignored.
- Misalign: half with addr[0]=1, or word with addr[1:0]!=0. Op completes in one cycle with out_misalign=1, out_memdata=0, no SB push, no DM read.
- Store: data = fwd_sel?fwd_data:rtdata, sampled in the push cycle. Byte data is replicated x4, half data x2. BE is 0001<<a, 0011<<a or 1111.
  - Push when count<SB_DEPTH, or when a drain occurs in the same cycle.
  - Otherwise stall: in_ready=0 and M holds.
  - A push entry cannot drain in its push cycle.
- Drain: at most one entry per cycle, oldest first. Drain writes BE lanes into DM. It is blocked when sb_hold=1 or when M holds a non-stalled load (the load owns the DM port).
- Load hazard: any valid SB entry with equal word index gives load stall. The load waits (drains allowed) until no match, then reads DM.
- Load completion: DM is read combinationally. Extended result goes to out_memdata at the next edge (1-cycle M→WB latency).
- out_valid: 1 for exactly one cycle per completed M op. Stalled or empty M gives out_valid=0 and out_* hold, except out_valid itself.
- in_ready = !(M valid && stall). A new op is accepted in the same cycle the current op completes.
- Count arithmetic: push and drain in the same cycle leave the count unchanged. Read/write pointers wrap mod SB_DEPTH.

Optional Feature:
SB_FWD_EN
- Defined: on a load hazard, if the youngest matching entry's BE covers every byte the load needs, forward that entry's data. The load completes with no stall, and the DM read is skipped. Partial coverage still stalls.
- Undefined: every match stalls, as above.

Test Plan:
- reset, sw 0x12345678 @0x10, lw @0x10 (no SB_FWD_EN) → lw stalls ≥1 cycle, out_memdata=0x12345678, out_valid one pulse.
- sb 0xAB @0x13 then lbu @0x13 → 0x000000AB. lb → 0xFFFFFFAB. lw @0x10 → 0xAB000000 (word previously zero).
- sb_hold=1, 4 sw to distinct words → sb_count=4. 5th sw: in_ready=0. Release hold → 5th accepted next cycle, count returns to 0 within 5 cycles.
- lh @0x11 → out_misalign=1, out_memdata=0, sb_count unchanged. Later lw @0x10 shows DM unchanged.
- sb_hold=1, 3 stores buffered, pulse reset=0 → sb_count=0, out_valid=0 immediately. lw of those addresses returns 0.
- SB_FWD_EN: sw 0xCAFEF00D @0x20, lw @0x20 next → out_memdata=0xCAFEF00D one cycle after M, no stall. sh 0xBEEF @0x24, lw @0x24 → stall until drained, then 0x0000BEEF.

Source files
------------

// File: rtl/mem_stage_sb.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_stage_sb                                               |
// | Description : EX/M pipeline register plus data-memory stage. Stores      |
// |               retire through a SB_DEPTH-entry store buffer into an       |
// |               internal single-port DM. Loads are sign/zero extended and  |
// |               registered toward WB.                                      |
// | Option      : `define SB_FWD_EN enables store-buffer-to-load forwarding. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mem_stage_sb #(
  parameter int ADDR_W   = 10,
  parameter int SB_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_instr,
  input  logic [31:0]               in_pc,
  input  logic [31:0]               in_aluout,
  input  logic [31:0]               in_rtdata,
  input  logic                      in_rd,
  input  logic                      in_wr,
  input  logic [1:0]                in_size,
  input  logic                      in_unsigned,
  input  logic                      fwd_sel,
  input  logic [31:0]               fwd_data,
  input  logic                      sb_hold,
  output logic                      out_valid,
  output logic [31:0]               out_instr,
  output logic [31:0]               out_pc,
  output logic [31:0]               out_pc8,
  output logic [31:0]               out_aluout,
  output logic [31:0]               out_memdata,
  output logic                      out_misalign,
  output logic [$clog2(SB_DEPTH):0] sb_count,
  output logic                      sb_empty
);

  localparam int               PTR_W     = $clog2(SB_DEPTH);
  localparam int               DM_WORDS  = 1 << ADDR_W;
  localparam logic [PTR_W:0]   C_SB_FULL = (PTR_W+1)'(SB_DEPTH);

  // M-stage operation register
  logic        m_valid_q;
  logic [31:0] m_instr_q, m_pc_q, m_alu_q, m_rt_q;
  logic        m_rd_q, m_wr_q, m_uns_q;
  logic [1:0]  m_size_q;

  // Store buffer (circular, oldest at read pointer)
  logic [ADDR_W-1:0] sb_widx_q [SB_DEPTH];
  logic [31:0]       sb_data_q [SB_DEPTH];
  logic [3:0]        sb_be_q   [SB_DEPTH];
  logic [SB_DEPTH-1:0] sb_vld_q;
  logic [PTR_W-1:0]  sb_wp_q, sb_rp_q;
  logic [PTR_W:0]    sb_cnt_q;

  // Data memory
  logic [31:0] dm_q [DM_WORDS];

  // WB-facing registers
  logic        out_valid_q, out_mis_q;
  logic [31:0] out_instr_q, out_pc_q, out_pc8_q, out_alu_q, out_mem_q;

  // Combinational datapath
  logic [1:0]        w_lane;
  logic [ADDR_W-1:0] w_widx;
  logic              w_mis, w_is_ld, w_is_st;
  logic [3:0]        w_need_be;
  logic [31:0]       w_st_src, w_st_data;
  logic              w_hit, w_fwd_ok;
  logic [PTR_W-1:0]  w_fwd_idx;
  logic              w_ld_stall, w_st_stall, w_stall, w_drain, w_push, w_done;
  logic [31:0]       w_ld_word, w_shift, w_ext, w_memdata;

  assign w_lane  = m_alu_q[1:0];
  assign w_widx  = m_alu_q[ADDR_W+1:2];
  // Size 11 is treated as a word access everywhere.
  assign w_mis   = ((m_size_q == 2'b01) && w_lane[0]) || (m_size_q[1] && (w_lane != 2'b00));
  assign w_is_ld = m_valid_q && m_rd_q && !w_mis;
  assign w_is_st = m_valid_q && m_wr_q && !w_mis;

  // Byte-enable and lane-replicated store data for the M-stage access
  always_comb begin
    w_need_be = 4'b1111;
    w_st_src  = fwd_sel ? fwd_data : m_rt_q;
    w_st_data = w_st_src;
    case (m_size_q)
      2'b00: begin
        w_need_be = 4'b0001 << w_lane;
        w_st_data = {4{w_st_src[7:0]}};
      end
      2'b01: begin
        w_need_be = 4'b0011 << w_lane;
        w_st_data = {2{w_st_src[15:0]}};
      end
      default: ;
    endcase
  end

  // Scan SB oldest-to-youngest; the last hit is the youngest matching entry
  always_comb begin
    logic [PTR_W-1:0] v_idx;
    v_idx     = '0;
    w_hit     = 1'b0;
    w_fwd_idx = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      v_idx = sb_rp_q + PTR_W'(k);
      if (sb_vld_q[v_idx] && (sb_widx_q[v_idx] == w_widx)) begin
        w_hit     = 1'b1;
        w_fwd_idx = v_idx;
      end
    end
  end

`ifdef SB_FWD_EN
  assign w_fwd_ok = w_hit && ((sb_be_q[w_fwd_idx] & w_need_be) == w_need_be);
`else
  assign w_fwd_ok = 1'b0;
`endif

  // A stalled load yields the DM port to draining; a live load owns it.
  assign w_ld_stall = w_is_ld && w_hit && !w_fwd_ok;
  assign w_drain    = (sb_cnt_q != '0) && !sb_hold && !(w_is_ld && !w_ld_stall);
  assign w_st_stall = w_is_st && (sb_cnt_q == C_SB_FULL) && !w_drain;
  assign w_push     = w_is_st && !w_st_stall;
  assign w_stall    = w_ld_stall || w_st_stall;
  assign w_done     = m_valid_q && !w_stall;
  assign in_ready   = !w_stall;

  // Load data selection and little-endian sign/zero extension
  always_comb begin
    w_ld_word = w_fwd_ok ? sb_data_q[w_fwd_idx] : dm_q[w_widx];
    w_shift   = w_ld_word >> {w_lane, 3'b000};
    case (m_size_q)
      2'b00:   w_ext = m_uns_q ? {24'h0, w_shift[7:0]}  : {{24{w_shift[7]}},  w_shift[7:0]};
      2'b01:   w_ext = m_uns_q ? {16'h0, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
      default: w_ext = w_shift;
    endcase
    w_memdata = (m_rd_q && !w_mis) ? w_ext : 32'h0;
  end

  // M register: capture a new op, retire a completed one, otherwise hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid_q <= 1'b0;
      m_instr_q <= '0;
      m_pc_q    <= '0;
      m_alu_q   <= '0;
      m_rt_q    <= '0;
      m_rd_q    <= 1'b0;
      m_wr_q    <= 1'b0;
      m_size_q  <= '0;
      m_uns_q   <= 1'b0;
    end else if (in_valid && in_ready) begin
      m_valid_q <= 1'b1;
      m_instr_q <= in_instr;
      m_pc_q    <= in_pc;
      m_alu_q   <= in_aluout;
      m_rt_q    <= in_rtdata;
      m_rd_q    <= in_rd;
      m_wr_q    <= in_wr;
      m_size_q  <= in_size;
      m_uns_q   <= in_unsigned;
    end else if (w_done) begin
      m_valid_q <= 1'b0;
    end
  end

  // Store buffer: push at write pointer, retire oldest at read pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_vld_q <= '0;
      sb_wp_q  <= '0;
      sb_rp_q  <= '0;
      sb_cnt_q <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_widx_q[i] <= '0;
        sb_data_q[i] <= '0;
        sb_be_q[i]   <= '0;
      end
    end else begin
      // Drain is cleared first so a same-slot push (full SB) wins.
      if (w_drain) begin
        sb_vld_q[sb_rp_q] <= 1'b0;
        sb_rp_q           <= sb_rp_q + 1'b1;
      end
      if (w_push) begin
        sb_vld_q[sb_wp_q]  <= 1'b1;
        sb_widx_q[sb_wp_q] <= w_widx;
        sb_data_q[sb_wp_q] <= w_st_data;
        sb_be_q[sb_wp_q]   <= w_need_be;
        sb_wp_q            <= sb_wp_q + 1'b1;
      end
      case ({w_push, w_drain})
        2'b10:   sb_cnt_q <= sb_cnt_q + 1'b1;
        2'b01:   sb_cnt_q <= sb_cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Data memory: drained entry writes only its enabled byte lanes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DM_WORDS; i++) begin
        dm_q[i] <= '0;
      end
    end else if (w_drain) begin
      for (int b = 0; b < 4; b++) begin
        if (sb_be_q[sb_rp_q][b]) begin
          dm_q[sb_widx_q[sb_rp_q]][8*b +: 8] <= sb_data_q[sb_rp_q][8*b +: 8];
        end
      end
    end
  end

  // WB register: one-cycle valid pulse per completed op, payload holds otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      out_pc8_q   <= '0;
      out_alu_q   <= '0;
      out_mem_q   <= '0;
      out_mis_q   <= 1'b0;
    end else if (w_done) begin
      out_valid_q <= 1'b1;
      out_instr_q <= m_instr_q;
      out_pc_q    <= m_pc_q;
      out_pc8_q   <= m_pc_q + 32'd8;
      out_alu_q   <= m_alu_q;
      out_mem_q   <= w_memdata;
      out_mis_q   <= w_mis;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_instr    = out_instr_q;
  assign out_pc       = out_pc_q;
  assign out_pc8      = out_pc8_q;
  assign out_aluout   = out_alu_q;
  assign out_memdata  = out_mem_q;
  assign out_misalign = out_mis_q;
  assign sb_count     = sb_cnt_q;
  assign sb_empty     = (sb_cnt_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_sb.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mem_stage_sb                                            |
// | Description : Directed self-checking bench for mem_stage_sb. Expected    |
// |               latencies adapt to the SB_FWD_EN build option.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mem_stage_sb;

  localparam int ADDR_W   = 10;
  localparam int SB_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc, in_aluout, in_rtdata;
  logic        in_rd, in_wr, in_unsigned;
  logic [1:0]  in_size;
  logic        fwd_sel;
  logic [31:0] fwd_data;
  logic        sb_hold;
  logic        out_valid, out_misalign, sb_empty;
  logic [31:0] out_instr, out_pc, out_pc8, out_aluout, out_memdata;
  logic [$clog2(SB_DEPTH):0] sb_count;

  int          checks   = 0;
  int          failures = 0;
  int unsigned seq      = 0;

  mem_stage_sb #(.ADDR_W(ADDR_W), .SB_DEPTH(SB_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_aluout(in_aluout), .in_rtdata(in_rtdata),
    .in_rd(in_rd), .in_wr(in_wr), .in_size(in_size), .in_unsigned(in_unsigned),
    .fwd_sel(fwd_sel), .fwd_data(fwd_data), .sb_hold(sb_hold),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_pc8(out_pc8),
    .out_aluout(out_aluout), .out_memdata(out_memdata), .out_misalign(out_misalign),
    .sb_count(sb_count), .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one op, wait (bounded) for acceptance; returns just after the accept edge.
  task automatic issue(input logic rd, input logic wr, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] data, output logic [31:0] instr);
    int n;
    seq++;
    instr       = 32'hC0DE_0000 + seq;
    in_valid    = 1'b1;
    in_instr    = instr;
    in_pc       = 32'h0000_1000 + (seq << 2);
    in_aluout   = addr;
    in_rtdata   = data;
    in_rd       = rd;
    in_wr       = wr;
    in_size     = size;
    in_unsigned = uns;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("issue_accept", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_rd    = 1'b0;
    in_wr    = 1'b0;
  endtask

  // Cycles from return of issue() until out_valid shows this instruction.
  task automatic wait_for(input logic [31:0] instr, output int cyc);
    cyc = 0;
    while (!(out_valid === 1'b1 && out_instr === instr) && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] ins;
    issue(1'b0, 1'b1, size, 1'b0, addr, data, ins);
  endtask

  task automatic load(input string tag, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] exp, output int cyc);
    logic [31:0] ins;
    issue(1'b1, 1'b0, size, uns, addr, 32'h0, ins);
    wait_for(ins, cyc);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_data"}, out_memdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    int          n;
    logic [31:0] ins;

    reset = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; in_aluout = '0;
    in_rtdata = '0; in_rd = 1'b0; in_wr = 1'b0; in_size = 2'b00; in_unsigned = 1'b0;
    fwd_sel = 1'b0; fwd_data = '0; sb_hold = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_memdata", out_memdata, 32'd0);
    chk("rst_sb_count", 32'(sb_count), 32'd0);
    chk("rst_sb_empty", {31'b0, sb_empty}, 32'd1);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    reset = 1'b1;
    tick();

    // sw then lw to the same word
    store(2'b10, 32'h10, 32'h1234_5678);
    load("lw1", 2'b10, 1'b0, 32'h10, 32'h1234_5678, cyc);
`ifdef SB_FWD_EN
    chk("lw1_latency", 32'(cyc), 32'd1);
`else
    chk("lw1_stall", (cyc >= 2) ? 32'd1 : 32'd0, 32'd1);
`endif
    chk("lw1_aluout", out_aluout, 32'h10);
    chk("lw1_pc8", out_pc8, 32'h0000_1000 + (seq << 2) + 32'd8);
    tick();
    chk("lw1_pulse", {31'b0, out_valid}, 32'd0);

    // Byte/half stores and sign/zero extension on a cleared memory
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    store(2'b00, 32'h13, 32'h0000_00AB);
    load("lbu", 2'b00, 1'b1, 32'h13, 32'h0000_00AB, cyc);
    load("lb",  2'b00, 1'b0, 32'h13, 32'hFFFF_FFAB, cyc);
    load("lw2", 2'b10, 1'b0, 32'h10, 32'hAB00_0000, cyc);
    store(2'b01, 32'h16, 32'h0000_8001);
    load("lh",  2'b01, 1'b0, 32'h16, 32'hFFFF_8001, cyc);
    load("lhu", 2'b01, 1'b1, 32'h16, 32'h0000_8001, cyc);
    load("lw3", 2'b10, 1'b0, 32'h14, 32'h8001_0000, cyc);

    // Store data taken from the forwarded WB result
    fwd_sel  = 1'b1;
    fwd_data = 32'h55AA_55AA;
    store(2'b10, 32'h70, 32'h1111_1111);
    tick();
    fwd_sel = 1'b0;
    load("lw_fwdsel", 2'b10, 1'b0, 32'h70, 32'h55AA_55AA, cyc);

    // Fill the SB under hold, 5th store stalls, then release
    sb_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      store(2'b10, 32'h40 + 32'(4 * i), 32'hA000_0000 + 32'(i));
    end
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h50, 32'h5555_AAAA, ins);
    chk("full_count", 32'(sb_count), 32'd4);
    chk("full_ready", {31'b0, in_ready}, 32'd0);
    tick();
    chk("full_ready2", {31'b0, in_ready}, 32'd0);
    chk("full_empty", {31'b0, sb_empty}, 32'd0);
    sb_hold = 1'b0;
    wait_for(ins, cyc);
    chk("release_latency", 32'(cyc), 32'd1);
    n = 0;
    while (sb_count != 0 && n < 5) begin
      tick();
      n++;
    end
    chk("release_drained", 32'(sb_count), 32'd0);
    chk("release_empty", {31'b0, sb_empty}, 32'd1);
    load("lw_4c", 2'b10, 1'b0, 32'h4C, 32'hA000_0003, cyc);
    load("lw_50", 2'b10, 1'b0, 32'h50, 32'h5555_AAAA, cyc);

    // Misaligned half load and misaligned word store
    issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, ins);
    wait_for(ins, cyc);
    chk("mis_lh_misalign", {31'b0, out_misalign}, 32'd1);
    chk("mis_lh_memdata", out_memdata, 32'd0);
    chk("mis_lh_count", 32'(sb_count), 32'd0);
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h12, 32'hDEAD_BEEF, ins);
    wait_for(ins, cyc);
    chk("mis_sw_misalign", {31'b0, out_misalign}, 32'd1);
    chk("mis_sw_count", 32'(sb_count), 32'd0);
    load("mis_lw_after", 2'b10, 1'b0, 32'h10, 32'hAB00_0000, cyc);
    chk("mis_lw_after_flag", {31'b0, out_misalign}, 32'd0);

    // Reset discards buffered stores
    sb_hold = 1'b1;
    store(2'b10, 32'h60, 32'h0000_0011);
    store(2'b10, 32'h64, 32'h0000_0022);
    store(2'b10, 32'h68, 32'h0000_0033);
    tick();
    chk("pre_rst_count", 32'(sb_count), 32'd3);
    chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    reset = 1'b0;
    #1;
    chk("async_rst_count", 32'(sb_count), 32'd0);
    chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
    tick();
    reset   = 1'b1;
    sb_hold = 1'b0;
    tick();
    load("lw_60", 2'b10, 1'b0, 32'h60, 32'h0, cyc);
    load("lw_68", 2'b10, 1'b0, 32'h68, 32'h0, cyc);

    // Full-coverage hazard (forwarded when enabled) vs partial coverage
    store(2'b10, 32'h20, 32'hCAFE_F00D);
    load("fwd_lw", 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D, cyc);
`ifdef SB_FWD_EN
    chk("fwd_lw_latency", 32'(cyc), 32'd1);
`else
    chk("fwd_lw_stall", (cyc >= 2) ? 32'd1 : 32'd0, 32'd1);
`endif
    store(2'b01, 32'h24, 32'h0000_BEEF);
    load("part_lw", 2'b10, 1'b0, 32'h24, 32'h0000_BEEF, cyc);
    chk("part_lw_stall", (cyc >= 2) ? 32'd1 : 32'd0, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
